arbitro_somador_sinal: RTL and testbench



---
 rtl/arbitro_somador_sinal.sv | 186 ++++++++++++++++++
 tb/tb_arbitro_somador_sinal.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_somador_sinal.sv
// Round-robin arbiter sharing one mixed-signedness adder between two requesters.
// Optional SATURACAO_EN clamps the result to the limits of its type on overflow.
module arbitro_somador_sinal #(
   parameter int LARGURA_A = 8,
   parameter int LARGURA_B = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [LARGURA_A-1:0] op_a0,
   input  logic [LARGURA_A-1:0] op_a1,
   input  logic [LARGURA_B-1:0] op_b0,
   input  logic [LARGURA_B-1:0] op_b1,
   input  logic [1:0]           codigo0,
   input  logic [1:0]           codigo1,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic                 resp_id,
   output logic [LARGURA_A-1:0] saida,
   output logic                 overflow,
   output logic [7:0]           contador_ops
);

   localparam int W = LARGURA_A + 2;
   // Limits of the result type, expressed in the extended sum width
   localparam logic [W-1:0] MAX_U = {{2{1'b0}}, {LARGURA_A{1'b1}}};
   localparam logic [W-1:0] MAX_S = {{3{1'b0}}, {(LARGURA_A-1){1'b1}}};
   localparam logic [W-1:0] MIN_S = {{3{1'b1}}, {(LARGURA_A-1){1'b0}}};

   typedef enum logic [1:0] {OCIOSO = 2'd0, CALCULA = 2'd1, ENTREGA = 2'd2} estado_t;

   estado_t              estado_q, estado_d;
   logic                 ultimo_q, ultimo_d;
   logic                 id_q, id_d;
   logic [LARGURA_A-1:0] op_a_q, op_a_d;
   logic [LARGURA_B-1:0] op_b_q, op_b_d;
   logic [1:0]           codigo_q, codigo_d;
   logic                 resp_valid_q, resp_valid_d;
   logic                 resp_id_q, resp_id_d;
   logic [LARGURA_A-1:0] saida_q, saida_d;
   logic                 overflow_q, overflow_d;
   logic [7:0]           contador_q, contador_d;

   logic                 concede_s;
   logic                 escolha_s;
   logic [W-1:0]         a_ext_s, b_ext_s, soma_s;
   logic                 acima_s, abaixo_s;
   logic [LARGURA_A-1:0] resultado_s;

   // Grant selection, active only while idle; ties go to the requester not served last
   always_comb begin
      concede_s = 1'b0;
      escolha_s = 1'b0;
      if (estado_q == OCIOSO) begin
         case (req_valid)
            2'b01:   begin concede_s = 1'b1; escolha_s = 1'b0;      end
            2'b10:   begin concede_s = 1'b1; escolha_s = 1'b1;      end
            2'b11:   begin concede_s = 1'b1; escolha_s = ~ultimo_q; end
            default: begin concede_s = 1'b0; escolha_s = 1'b0;      end
         endcase
      end else begin
         concede_s = 1'b0;
         escolha_s = 1'b0;
      end
      if (concede_s) begin
         req_ready = escolha_s ? 2'b10 : 2'b01;
      end else begin
         req_ready = 2'b00;
      end
   end

   // Extended sum, overflow detection and the value presented as result
   always_comb begin
      a_ext_s  = {{(W-LARGURA_A){codigo_q[0] & op_a_q[LARGURA_A-1]}}, op_a_q};
      b_ext_s  = {{(W-LARGURA_B){codigo_q[1] & op_b_q[LARGURA_B-1]}}, op_b_q};
      soma_s   = a_ext_s + b_ext_s;
      acima_s  = 1'b0;
      abaixo_s = 1'b0;
      if (codigo_q == 2'b00) begin
         acima_s  = (soma_s > MAX_U);
         abaixo_s = 1'b0;
      end else begin
         acima_s  = ($signed(soma_s) > $signed(MAX_S));
         abaixo_s = ($signed(soma_s) < $signed(MIN_S));
      end
`ifdef SATURACAO_EN
      if (acima_s && (codigo_q == 2'b00)) begin
         resultado_s = {LARGURA_A{1'b1}};
      end else if (acima_s) begin
         resultado_s = {1'b0, {(LARGURA_A-1){1'b1}}};
      end else if (abaixo_s) begin
         resultado_s = {1'b1, {(LARGURA_A-1){1'b0}}};
      end else begin
         resultado_s = soma_s[LARGURA_A-1:0];
      end
`else
      resultado_s = soma_s[LARGURA_A-1:0];
`endif
   end

   // Sequencer next-state: accept, compute, deliver
   always_comb begin
      estado_d     = estado_q;
      ultimo_d     = ultimo_q;
      id_d         = id_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      codigo_d     = codigo_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      saida_d      = saida_q;
      overflow_d   = overflow_q;
      contador_d   = contador_q;
      case (estado_q)
         OCIOSO: begin
            if (concede_s) begin
               op_a_d   = escolha_s ? op_a1 : op_a0;
               op_b_d   = escolha_s ? op_b1 : op_b0;
               codigo_d = escolha_s ? codigo1 : codigo0;
               id_d     = escolha_s;
               ultimo_d = escolha_s;
               estado_d = CALCULA;
            end else begin
               estado_d = OCIOSO;
            end
         end
         CALCULA: begin
            saida_d      = resultado_s;
            overflow_d   = acima_s | abaixo_s;
            resp_id_d    = id_q;
            resp_valid_d = 1'b1;
            estado_d     = ENTREGA;
         end
         ENTREGA: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               contador_d   = contador_q + 8'd1;
               estado_d     = OCIOSO;
            end else begin
               estado_d = ENTREGA;
            end
         end
         default: begin
            resp_valid_d = 1'b0;
            estado_d     = OCIOSO;
         end
      endcase
   end

   // State and output registers; reset discards any in-flight request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q     <= OCIOSO;
         ultimo_q     <= 1'b1;
         id_q         <= 1'b0;
         op_a_q       <= {LARGURA_A{1'b0}};
         op_b_q       <= {LARGURA_B{1'b0}};
         codigo_q     <= 2'b00;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         saida_q      <= {LARGURA_A{1'b0}};
         overflow_q   <= 1'b0;
         contador_q   <= 8'd0;
      end else begin
         estado_q     <= estado_d;
         ultimo_q     <= ultimo_d;
         id_q         <= id_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         codigo_q     <= codigo_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         saida_q      <= saida_d;
         overflow_q   <= overflow_d;
         contador_q   <= contador_d;
      end
   end

   assign resp_valid   = resp_valid_q;
   assign resp_id      = resp_id_q;
   assign saida        = saida_q;
   assign overflow     = overflow_q;
   assign contador_ops = contador_q;

endmodule

// File: tb/tb_arbitro_somador_sinal.sv
// Scoreboard bench for arbitro_somador_sinal: a negedge monitor models the
// round-robin grant, pushes expected results on accept and pops them on response.
module tb_arbitro_somador_sinal;

   typedef struct packed {
      logic       id;
      logic [7:0] saida;
      logic       ovf;
   } res_t;

   logic       clk;
   logic       rst;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [7:0] op_a0, op_a1;
   logic [3:0] op_b0, op_b1;
   logic [1:0] codigo0, codigo1;
   logic       resp_valid;
   logic       resp_ready;
   logic       resp_id;
   logic [7:0] saida;
   logic       overflow;
   logic [7:0] contador_ops;

   int   tests_run;
   int   failures;
   res_t fila[$];
   logic ids_vistos[$];
   logic ultimo_m;
   logic [7:0] cnt_m;

   arbitro_somador_sinal #(.LARGURA_A(8), .LARGURA_B(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .op_a0(op_a0), .op_a1(op_a1), .op_b0(op_b0), .op_b1(op_b1),
      .codigo0(codigo0), .codigo1(codigo1),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .saida(saida), .overflow(overflow), .contador_ops(contador_ops)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic res_t modelo(input logic id, input logic [7:0] a,
                                   input logic [3:0] b, input logic [1:0] cod);
      int          av, bv, s;
      logic [31:0] su;
      res_t        r;
      av = int'(a);
      if (cod[0] && a[7]) av = av - 256;
      bv = int'(b);
      if (cod[1] && b[3]) bv = bv - 16;
      s    = av + bv;
      r.id = id;
      if (cod == 2'b00) r.ovf = (s > 255);
      else              r.ovf = (s > 127) || (s < -128);
      su      = s;
      r.saida = su[7:0];
`ifdef SATURACAO_EN
      if (r.ovf) begin
         if (cod == 2'b00)  r.saida = 8'hFF;
         else if (s > 127)  r.saida = 8'h7F;
         else               r.saida = 8'h80;
      end
`endif
      return r;
   endfunction

   task automatic monitor();
      logic g;
      res_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (req_ready != 2'b00) begin
               tests_run++;
               if (req_valid == 2'b00) begin
                  failures++;
                  $display("FAIL grant_sem_pedido req_ready=%b req_valid=%b", req_ready, req_valid);
                  g = req_ready[1];
               end else begin
                  if (req_valid == 2'b01)      g = 1'b0;
                  else if (req_valid == 2'b10) g = 1'b1;
                  else                         g = ~ultimo_m;
                  if (req_ready !== (g ? 2'b10 : 2'b01)) begin
                     failures++;
                     $display("FAIL grant got=%b exp=%b", req_ready, (g ? 2'b10 : 2'b01));
                  end
               end
               fila.push_back(modelo(g, g ? op_a1 : op_a0, g ? op_b1 : op_b0, g ? codigo1 : codigo0));
               ultimo_m = g;
            end
            if (resp_valid && resp_ready) begin
               tests_run++;
               if (fila.size() == 0) begin
                  failures++;
                  $display("FAIL resp_inesperada id=%b saida=%h", resp_id, saida);
               end else begin
                  e = fila.pop_front();
                  if ({resp_id, saida, overflow} !== e) begin
                     failures++;
                     $display("FAIL resultado got id=%b saida=%h ovf=%b exp id=%b saida=%h ovf=%b",
                              resp_id, saida, overflow, e.id, e.saida, e.ovf);
                  end
               end
               tests_run++;
               if (contador_ops !== cnt_m) begin
                  failures++;
                  $display("FAIL contador got=%0d exp=%0d", contador_ops, cnt_m);
               end
               cnt_m = cnt_m + 8'd1;
               ids_vistos.push_back(resp_id);
            end
         end
      end
   endtask

   task automatic limpar_modelo();
      fila.delete();
      ids_vistos.delete();
      ultimo_m = 1'b1;
      cnt_m    = 8'd0;
   endtask

   task automatic esperar_fim();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!resp_valid && fila.size() == 0 && req_ready == 2'b00) begin
            ok = 1'b1;
            break;
         end
      end
      tests_run++;
      if (!ok) begin
         failures++;
         $display("FAIL drenagem resp_valid=%b fila=%0d exp vazio", resp_valid, fila.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 2'b00; resp_ready = 1'b0;
      op_a0 = 8'h00; op_a1 = 8'h00; op_b0 = 4'h0; op_b1 = 4'h0;
      codigo0 = 2'b00; codigo1 = 2'b00;
      limpar_modelo();
      repeat (2) @(negedge clk);
      tests_run++;
      if ({req_ready, resp_valid, resp_id, saida, overflow, contador_ops} !== 20'd0) begin
         failures++;
         $display("FAIL reset got rr=%b rv=%b id=%b s=%h o=%b c=%0d exp all 0",
                  req_ready, resp_valid, resp_id, saida, overflow, contador_ops);
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic pedido(input logic id, input logic [7:0] a, input logic [3:0] b,
                         input logic [1:0] cod, input logic [7:0] exp_s, input logic exp_o);
      bit ok;
      ok = 1'b0;
      resp_ready = 1'b0;
      if (id) begin op_a1 = a; op_b1 = b; codigo1 = cod; req_valid = 2'b10; end
      else    begin op_a0 = a; op_b0 = b; codigo0 = cod; req_valid = 2'b01; end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready[id]) begin ok = 1'b1; break; end
      end
      tests_run++;
      if (!ok) begin
         failures++;
         $display("FAIL grant_timeout id=%b req_ready=%b", id, req_ready);
         req_valid = 2'b00;
         return;
      end
      @(posedge clk); #1 req_valid = 2'b00;
      // first edge after accept is the compute cycle; the response shows after the next
      @(negedge clk);
      tests_run++;
      if (resp_valid !== 1'b0) begin
         failures++; $display("FAIL latencia_cedo resp_valid=%b exp 0", resp_valid);
      end
      @(negedge clk);
      tests_run++;
      if (resp_valid !== 1'b1) begin
         failures++; $display("FAIL latencia resp_valid=%b exp 1", resp_valid);
      end
      tests_run++;
      if ({resp_id, saida, overflow} !== {id, exp_s, exp_o}) begin
         failures++;
         $display("FAIL vetor got id=%b saida=%h ovf=%b exp id=%b saida=%h ovf=%b",
                  resp_id, saida, overflow, id, exp_s, exp_o);
      end
      @(posedge clk); #1 resp_ready = 1'b1;
      esperar_fim();
   endtask

   task automatic test_basico();
`ifdef SATURACAO_EN
      pedido(1'b0, 8'hFA, 4'hA, 2'b00, 8'hFF, 1'b1);
      pedido(1'b1, 8'h80, 4'hF, 2'b11, 8'h80, 1'b1);
`else
      pedido(1'b0, 8'hFA, 4'hA, 2'b00, 8'h04, 1'b1);
      pedido(1'b1, 8'h80, 4'hF, 2'b11, 8'h7F, 1'b1);
`endif
      pedido(1'b0, 8'hFF, 4'h8, 2'b01, 8'h07, 1'b0);
      pedido(1'b0, 8'h05, 4'hE, 2'b10, 8'h03, 1'b0);
   endtask

   task automatic test_back_to_back();
      rst = 1'b1;
      limpar_modelo();
      @(posedge clk); #1 rst = 1'b0;
      resp_ready = 1'b1;
      op_a0 = 8'h7F; op_b0 = 4'h1; codigo0 = 2'b11;
      op_a1 = 8'h10; op_b1 = 4'h3; codigo1 = 2'b00;
      req_valid = 2'b11;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (cnt_m == 8'd4) break;
      end
      @(posedge clk); #1 req_valid = 2'b00;
      esperar_fim();
      tests_run++;
      if (ids_vistos.size() != 4) begin
         failures++; $display("FAIL b2b_qtd got=%0d exp=4", ids_vistos.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (ids_vistos[i] !== i[0]) begin
               failures++; $display("FAIL b2b_id[%0d] got=%b exp=%b", i, ids_vistos[i], i[0]);
            end
         end
      end
      tests_run++;
      if (contador_ops !== 8'd4) begin
         failures++; $display("FAIL b2b_contador got=%0d exp=4", contador_ops);
      end
   endtask

   task automatic test_hold();
      bit         ok;
      res_t       cap;
      res_t       e;
      logic [7:0] c0;
      ok = 1'b0;
      resp_ready = 1'b0;
      op_a0 = 8'h64; op_b0 = 4'h7; codigo0 = 2'b01;
      op_a1 = 8'hF0; op_b1 = 4'hF; codigo1 = 2'b00;
      req_valid = 2'b11;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (resp_valid) begin ok = 1'b1; break; end
      end
      tests_run++;
      if (!ok) begin
         failures++; $display("FAIL hold_timeout resp_valid=%b exp 1", resp_valid);
      end
      cap = {resp_id, saida, overflow};
      c0  = contador_ops;
      e   = modelo(1'b0, 8'h64, 4'h7, 2'b01);
      tests_run++;
      if (cap !== e) begin
         failures++; $display("FAIL hold_valor got=%h exp=%h", cap, e);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if ({resp_id, saida, overflow} !== cap || req_ready !== 2'b00 ||
             contador_ops !== c0 || resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_estavel got=%h rr=%b c=%0d rv=%b exp=%h rr=00 c=%0d rv=1",
                     {resp_id, saida, overflow}, req_ready, contador_ops, resp_valid, cap, c0);
         end
      end
      @(posedge clk); #1 resp_ready = 1'b1;
      @(posedge clk); #1 req_valid = 2'b00;
      esperar_fim();
      tests_run++;
      if (contador_ops !== c0 + 8'd1) begin
         failures++; $display("FAIL hold_contador got=%0d exp=%0d", contador_ops, c0 + 8'd1);
      end
   endtask

   task automatic test_reset_meio();
      bit ok;
      ok = 1'b0;
      resp_ready = 1'b1;
      op_a0 = 8'h11; op_b0 = 4'h2; codigo0 = 2'b00;
      req_valid = 2'b01;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready[0]) begin ok = 1'b1; break; end
      end
      tests_run++;
      if (!ok) begin
         failures++; $display("FAIL rmeio_grant req_ready=%b exp 01", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      rst = 1'b1;
      #1;
      tests_run++;
      if (resp_valid !== 1'b0 || contador_ops !== 8'd0 || req_ready !== 2'b00) begin
         failures++;
         $display("FAIL rmeio_reset rv=%b c=%0d rr=%b exp 0 0 00", resp_valid, contador_ops, req_ready);
      end
      limpar_modelo();
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (resp_valid !== 1'b0) begin
         failures++; $display("FAIL rmeio_descartado resp_valid=%b exp 0", resp_valid);
      end
      @(posedge clk); #1;
      op_a0 = 8'h20; op_b0 = 4'h5; codigo0 = 2'b00;
      op_a1 = 8'h30; op_b1 = 4'h6; codigo1 = 2'b00;
      req_valid = 2'b11;
      @(negedge clk);
      tests_run++;
      if (req_ready !== 2'b01) begin
         failures++; $display("FAIL rmeio_prioridade got=%b exp=01", req_ready);
      end
      @(posedge clk); #1 req_valid = 2'b00;
      esperar_fim();
      tests_run++;
      if (contador_ops !== 8'd1) begin
         failures++; $display("FAIL rmeio_contador got=%0d exp=1", contador_ops);
      end
   endtask

   initial begin
      tests_run = 0;
      failures  = 0;
      rst       = 1'b1;
      ultimo_m  = 1'b1;
      cnt_m     = 8'd0;
      fork
         monitor();
         begin
            #200000;
            $display("FAIL watchdog tempo esgotado");
            $fatal(1, "watchdog");
         end
      join_none
      test_reset();
      test_basico();
      test_back_to_back();
      test_hold();
      test_reset_meio();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
